ntt_stage_sched: RTL and testbench
==================================

Name: ntt_stage_sched

Overview:
- Sequencer for an in-place radix-2 Cooley-Tukey NTT of N = 2^LOGN points.
- Drives one pipelined butterfly PE (modulus 7681 datapath) plus a dual-port coefficient RAM and a twiddle ROM.
- Generates read addresses, twiddle indices and delayed write-back addresses for every butterfly of every stage.
- Inserts drain bubbles between stages to remove RAW hazards, and reports busy/done to the top-level controller.

Parameters:
- LOGN, 8, log2 of transform size; N = 1<<LOGN; legal range 2..12.
- PE_LAT, 3, cycles from read issue to write-back. Covers RAM read latency plus PE pipeline depth. Must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- hold  in  1  stall request; suppresses issue while in RUN.
- busy  out  1  high from the first issue cycle through the final write-back cycle.
- done  out  1  one-cycle pulse after the final write-back.
- stage_o  out  LOGN  current stage index s.
- rd_en  out  1  read/issue strobe for one butterfly.
- rd_addr_top  out  LOGN  RAM address of the top operand.
- rd_addr_bot  out  LOGN  RAM address of the bottom operand.
- tw_addr  out  LOGN-1  twiddle ROM index, aligned with rd_en.
- wr_en  out  1  write-back strobe.
- wr_addr_top  out  LOGN  write address for the PE top output.
- wr_addr_bot  out  LOGN  write address for the PE bottom output.

Behaviour:
- States:
  - IDLE: start=1 at an edge -> RUN, with s=0 and j=0.
  - RUN: issues butterflies j = 0..N/2-1. After the edge that issues j=N/2-1 -> DRAIN.
  - DRAIN: lasts exactly PE_LAT cycles. Then, if s<LOGN-1, s++ and j=0 -> RUN; otherwise -> IDLE with done=1 for that one cycle.
- Issue: rd_en = (state==RUN) && !hold, combinational. j advances only on edges where rd_en=1. hold is ignored in IDLE and DRAIN.
- Address math, with m = 1<<s and k = j & (m-1):
  - top = ((j>>s)<<(s+1)) | k.
  - bot = top | m.
  - tw_addr = k << (LOGN-1-s).
  - All arithmetic is unsigned and truncation-free at the stated widths.
- Write-back: a PE_LAT-deep shift register carries {valid, top, bot}. wr_en, wr_addr_top and wr_addr_bot equal the issue values delayed by exactly PE_LAT cycles. Hold bubbles propagate as wr_en=0.
- Hazard rule: the first issue of stage s+1 occurs the cycle after the last wr_en of stage s. The RAM is write-before-read across edges.
- Cycle count with no hold: LOGN*(N/2+PE_LAT) busy cycles, then the done cycle.
- busy = (state==RUN) || (state==DRAIN). busy is low in the done cycle.
- start while busy is ignored. start in the done cycle is accepted, because the state is already IDLE; RUN begins the next cycle.
- Reset values:
  - state IDLE, s=0, j=0, pipeline valid bits cleared.
  - All outputs 0: busy, done, rd_en, wr_en, stage_o and all addresses.
- Reset mid-transform: next cycle is IDLE, no further wr_en, no done pulse.
- Addresses when rd_en=0 or wr_en=0 are don't-care. The bench must not check them.

Test Plan:
- LOGN=3, PE_LAT=3, start at cycle 0:
  - Stage 0: rd (top,bot,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0) in cycles 1-4.
  - Stage 1: (0,2,0),(1,3,2),(4,6,0),(5,7,2) in cycles 8-11.
  - Stage 2: (0,4,0),(1,5,1),(2,6,2),(3,7,3) in cycles 15-18.
  - done pulses at cycle 22; busy high for cycles 1-21.
- Write pipeline: each wr_en/address pair matches the rd pair issued exactly 3 cycles earlier. No wr_en occurs in any cycle where rd_en is high for the following stage's first butterfly before the prior stage's final write completes.
- hold high during cycles 2-3 of stage 0: rd_en low those cycles, issue of j=1 moves to cycle 4, bubbles appear on wr_en at cycles 5-6, done is delayed by 2 cycles to cycle 24.
- start pulsed again at cycles 5 and 12 during the run: ignored, with no change to address sequence or timing. start in the done cycle 22: stage-0 issue restarts at cycle 23.
- reset asserted at cycle 9 (mid stage 1): from cycle 10, busy=0, rd_en=0, wr_en=0, and no done pulse. A subsequent start reproduces the stage-0 sequence from j=0.
- LOGN=8, PE_LAT=5 full run: 8*(128+5)=1064 busy cycles. Each RAM address is written exactly twice... rather exactly once per stage (256 writes/stage total via top+bot). Last-stage tw_addr runs 0..127.

Source files
------------

// File: rtl/ntt_stage_sched_if.sv
// Purpose: bundles the NTT scheduler's control handshake and RAM/ROM/PE address strobes.
// Latency: none, wires only.
// Backpressure: host drives hold to stall butterfly issue; there is no ready path back.
interface ntt_stage_sched_if #(
  parameter int LOGN = 8
);
  logic            start;
  logic            hold;
  logic            busy;
  logic            done;
  logic [LOGN-1:0] stage_o;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_top;
  logic [LOGN-1:0] rd_addr_bot;
  logic [LOGN-2:0] tw_addr;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_top;
  logic [LOGN-1:0] wr_addr_bot;

  // Scheduler side
  modport master (
    input  start, hold,
    output busy, done, stage_o,
    output rd_en, rd_addr_top, rd_addr_bot, tw_addr,
    output wr_en, wr_addr_top, wr_addr_bot
  );

  // Controller / memory side
  modport slave (
    output start, hold,
    input  busy, done, stage_o,
    input  rd_en, rd_addr_top, rd_addr_bot, tw_addr,
    input  wr_en, wr_addr_top, wr_addr_bot
  );
endinterface

// File: rtl/ntt_stage_sched.sv
// Purpose: sequences an in-place radix-2 Cooley-Tukey NTT: read/twiddle/write-back addresses per butterfly.
// Latency: issue is combinational; write-back strobes trail issue by PE_LAT cycles; done one cycle after last write.
// Backpressure: hold stalls issue in RUN (bubbles flow down the write pipe); drain of PE_LAT cycles between stages.
module ntt_stage_sched #(
  parameter int LOGN   = 8,
  parameter int PE_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  ntt_stage_sched_if.master  bus
);

  localparam int JW = LOGN - 1;
  localparam int CW = $clog2(PE_LAT + 1);
  localparam logic [LOGN-1:0] S_MAX = LOGN'(LOGN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LOGN-1:0] s;
  logic [JW-1:0]   j;
  logic [CW-1:0]   dcnt;
  logic            issue;
  logic            j_last;
  logic            s_last;
  logic            drain_end;
  logic            done_q;

  logic [LOGN-1:0] jx;
  logic [JW-1:0]   mask;
  logic [JW-1:0]   k;
  logic [LOGN-1:0] top;
  logic [LOGN-1:0] bot;
  logic [JW-1:0]   twj;

  // Write-back delay line: one slot per cycle of read + PE latency
  logic [PE_LAT-1:0] pv;
  logic [LOGN-1:0]   pt [PE_LAT];
  logic [LOGN-1:0]   pb [PE_LAT];

  assign j_last    = (j == {JW{1'b1}});
  assign s_last    = (s == S_MAX);
  assign drain_end = (dcnt == CW'(PE_LAT - 1));

  // Next-state and issue decode; hold only matters while issuing
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        issue = !bus.hold;
        if (issue && j_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_end) state_nxt = s_last ? IDLE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage index, butterfly index and drain counter; j wraps to 0 on the last issue
  always_ff @(posedge clk) begin
    if (reset) begin
      s    <= '0;
      j    <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          s    <= '0;
          j    <= '0;
          dcnt <= '0;
        end
        RUN: begin
          if (issue) j <= j + 1'b1;
          dcnt <= '0;
        end
        DRAIN: begin
          if (drain_end) begin
            dcnt <= '0;
            s    <= s_last ? '0 : s + 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          dcnt <= '0;
        end
      endcase
    end
  end

  // Butterfly address math: insert a zero at bit s of j for top, set it for bot.
  // The mask is formed in JW bits so that s = LOGN-1 overflows 1<<s to 0 and yields all ones.
  always_comb begin
    jx   = {1'b0, j};
    mask = (JW'(1) << s) - JW'(1);
    k    = j & mask;
    top  = ((jx >> s) << (s + 1'b1)) | {1'b0, k};
    bot  = top | (LOGN'(1) << s);
    twj  = k << (S_MAX - s);
  end

  assign bus.rd_en       = issue;
  assign bus.rd_addr_top = issue ? top : '0;
  assign bus.rd_addr_bot = issue ? bot : '0;
  assign bus.tw_addr     = issue ? twj : '0;
  assign bus.busy        = (state == RUN) || (state == DRAIN);
  assign bus.stage_o     = s;
  assign bus.done        = done_q;

  // Shift issue strobe and gated addresses down the write-back pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < PE_LAT; i++) begin
        pt[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pv[0] <= issue;
      pt[0] <= bus.rd_addr_top;
      pb[0] <= bus.rd_addr_bot;
      for (int i = 1; i < PE_LAT; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  assign bus.wr_en       = pv[PE_LAT-1];
  assign bus.wr_addr_top = pt[PE_LAT-1];
  assign bus.wr_addr_bot = pb[PE_LAT-1];

  // Done pulses on the cycle after the final drain cycle of the last stage
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state == DRAIN) && drain_end && s_last;
  end

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Purpose: scoreboard bench for ntt_stage_sched at LOGN=3/PE_LAT=3 (directed + random hold) and LOGN=8/PE_LAT=5.
// Latency: expected write-backs are due exactly PE_LAT cycles after each observed issue.
// Backpressure: hold and stray start pulses are driven randomly; the model tracks their effect on issue.
module tb_ntt_stage_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int stage;
    int top;
    int bot;
    int tw;
    bit first;
    bit last;
    bit fin;
  } bf_t;

  typedef struct {
    int top;
    int bot;
    int due;
    bit fin;
  } wb_t;

  ntt_stage_sched_if #(.LOGN(3)) ia ();
  ntt_stage_sched_if #(.LOGN(8)) ib ();

  ntt_stage_sched #(.LOGN(3), .PE_LAT(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia.master)
  );

  ntt_stage_sched #(.LOGN(8), .PE_LAT(5)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib.master)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference butterfly ordering: the idx-th index i (ascending) with bit s clear pairs with i+2^s;
  // its twiddle is (i mod 2^s) scaled by N/2^(s+1).
  function automatic void ref_bf(input int lg, input int s, input int idx,
                                 output int top, output int bot, output int tw);
    int m;
    m   = 1 << s;
    top = (idx / m) * 2 * m + (idx % m);
    bot = top + m;
    tw  = (idx % m) * ((1 << lg) / (2 * m));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT A scoreboard/monitor ----------------
  bf_t qa[$];
  wb_t wa[$];
  bit  a_live     = 1'b0;
  int  a_gap      = 0;
  int  a_exp_done = -1;
  int  a_first_rd = -1;
  int  a_busy_cnt = 0;

  always @(negedge clk) begin
    bf_t b;
    wb_t w;
    bit  exp_rd;
    bit  exp_wr;
    chk("a_busy", ia.busy, a_live);
    if (ia.busy) a_busy_cnt++;
    exp_rd = a_live && !ia.hold && (a_gap == 0) && (qa.size() > 0);
    chk("a_rd_en", ia.rd_en, exp_rd);
    if (a_gap > 0) a_gap--;
    if (ia.rd_en && qa.size() > 0) begin
      b = qa.pop_front();
      chk("a_rd_top", ia.rd_addr_top, b.top);
      chk("a_rd_bot", ia.rd_addr_bot, b.bot);
      chk("a_tw", ia.tw_addr, b.tw);
      chk("a_stage", ia.stage_o, b.stage);
      w.top = b.top;
      w.bot = b.bot;
      w.due = cyc + 3;
      w.fin = b.fin;
      wa.push_back(w);
      if (b.last && !b.fin) a_gap = 3;
      if (b.first) a_first_rd = cyc;
    end
    exp_wr = (wa.size() > 0) && (wa[0].due == cyc);
    chk("a_wr_en", ia.wr_en, exp_wr);
    if (ia.wr_en && exp_wr) begin
      w = wa.pop_front();
      chk("a_wr_top", ia.wr_addr_top, w.top);
      chk("a_wr_bot", ia.wr_addr_bot, w.bot);
      if (w.fin) begin
        a_exp_done = cyc + 1;
        a_live     = 1'b0;
      end
    end
    chk("a_done", ia.done, (cyc == a_exp_done));
    if (ia.start && !ia.busy && !reset) a_live = 1'b1;
    if (reset) begin
      a_live     = 1'b0;
      a_gap      = 0;
      a_exp_done = -1;
      qa.delete();
      wa.delete();
    end
  end

  // Issue a transform request on A and queue its full expected butterfly list
  task automatic start_a(output int s_cyc);
    bf_t b;
    for (int s = 0; s < 3; s++) begin
      for (int idx = 0; idx < 4; idx++) begin
        ref_bf(3, s, idx, b.top, b.bot, b.tw);
        b.stage = s;
        b.first = (s == 0) && (idx == 0);
        b.last  = (idx == 3);
        b.fin   = (s == 2) && (idx == 3);
        qa.push_back(b);
      end
    end
    a_busy_cnt = 0;
    a_first_rd = -1;
    ia.start   = 1'b1;
    s_cyc      = cyc;
    tick();
    ia.start   = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input bit rnd, output int d);
    d = -1;
    for (int i = 0; i < budget; i++) begin
      if (ia.done) begin
        ia.hold  = 1'b0;
        ia.start = 1'b0;
        d = cyc;
        return;
      end
      if (rnd) begin
        ia.hold  = ($urandom_range(0, 3) == 0);
        ia.start = ia.busy && ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    ia.hold  = 1'b0;
    ia.start = 1'b0;
    chk("a_done_timeout", 0, 1);
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_busy"}, ia.busy, 0);
    chk({tag, "_done"}, ia.done, 0);
    chk({tag, "_rd_en"}, ia.rd_en, 0);
    chk({tag, "_wr_en"}, ia.wr_en, 0);
    chk({tag, "_stage"}, ia.stage_o, 0);
    chk({tag, "_rd_top"}, ia.rd_addr_top, 0);
    chk({tag, "_rd_bot"}, ia.rd_addr_bot, 0);
    chk({tag, "_tw"}, ia.tw_addr, 0);
    chk({tag, "_wr_top"}, ia.wr_addr_top, 0);
    chk({tag, "_wr_bot"}, ia.wr_addr_bot, 0);
  endtask

  // ---------------- DUT B monitor (LOGN=8, PE_LAT=5) ----------------
  wb_t wbq[$];
  int  b_idx      = 0;
  int  b_wr_num   = 0;
  int  b_busy_cnt = 0;
  int  b_last_wr  = -1;
  int  wcnt[256];

  always @(negedge clk) begin
    int  t;
    int  bo;
    int  tw;
    int  nbad;
    wb_t w;
    if (ib.busy) b_busy_cnt++;
    if (ib.rd_en) begin
      ref_bf(8, b_idx / 128, b_idx % 128, t, bo, tw);
      chk("b_rd_top", ib.rd_addr_top, t);
      chk("b_rd_bot", ib.rd_addr_bot, bo);
      chk("b_tw", ib.tw_addr, tw);
      chk("b_stage", ib.stage_o, b_idx / 128);
      if (b_idx / 128 == 7) chk("b_tw_last_stage", ib.tw_addr, b_idx % 128);
      w.top = t;
      w.bot = bo;
      w.due = cyc + 5;
      w.fin = 1'b0;
      wbq.push_back(w);
      b_idx++;
    end
    chk("b_wr_en", ib.wr_en, (wbq.size() > 0) && (wbq[0].due == cyc));
    if (ib.wr_en && wbq.size() > 0) begin
      w = wbq.pop_front();
      chk("b_wr_top", ib.wr_addr_top, w.top);
      chk("b_wr_bot", ib.wr_addr_bot, w.bot);
      wcnt[ib.wr_addr_top]++;
      wcnt[ib.wr_addr_bot]++;
      b_wr_num++;
      b_last_wr = cyc;
      if (b_wr_num % 128 == 0) begin
        nbad = 0;
        foreach (wcnt[i]) if (wcnt[i] != 1) nbad++;
        chk("b_stage_write_cover", nbad, 0);
        foreach (wcnt[i]) wcnt[i] = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus ----------------
  initial begin
    int s0;
    int d;
    int s2;
    int d2;
    int bd;
    ia.start = 1'b0;
    ia.hold  = 1'b0;
    ib.start = 1'b0;
    ib.hold  = 1'b0;
    foreach (wcnt[i]) wcnt[i] = 0;

    reset = 1'b1;
    repeat (3) tick();
    check_zero_a("rst");
    chk("rst_b_busy", ib.busy, 0);
    chk("rst_b_wr_en", ib.wr_en, 0);
    reset = 1'b0;
    repeat (2) tick();

    // Plain run: reads 1-4 / 8-11 / 15-18, done at +22, 21 busy cycles
    start_a(s0);
    wait_done_a(200, 1'b0, d);
    chk("a_done_lat", d - s0, 22);
    chk("a_busy_cycles", a_busy_cnt, 21);
    chk("a_first_rd_lat", a_first_rd - s0, 1);
    repeat (3) tick();

    // Hold during cycles 2-3 of stage 0 pushes done to +24
    start_a(s0);
    tick();
    ia.hold = 1'b1;
    repeat (2) tick();
    ia.hold = 1'b0;
    wait_done_a(200, 1'b0, d);
    chk("a_hold_done_lat", d - s0, 24);
    repeat (2) tick();

    // Stray starts at +5 and +12 are ignored; restart in the done cycle
    start_a(s0);
    while (cyc < s0 + 13) begin
      ia.start = (cyc == s0 + 5) || (cyc == s0 + 12);
      tick();
    end
    ia.start = 1'b0;
    wait_done_a(200, 1'b0, d);
    chk("a_ignored_start_done_lat", d - s0, 22);
    chk("a_ignored_start_busy", a_busy_cnt, 21);
    start_a(s2);
    wait_done_a(200, 1'b0, d2);
    chk("a_restart_first_rd", a_first_rd - d, 1);
    chk("a_restart_done_lat", d2 - s2, 22);
    repeat (2) tick();

    // Reset in the middle of stage 1
    start_a(s0);
    while (cyc < s0 + 9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero_a("midrst");
    repeat (8) tick();
    start_a(s0);
    wait_done_a(200, 1'b0, d);
    chk("a_post_rst_first_rd", a_first_rd - s0, 1);
    chk("a_post_rst_done_lat", d - s0, 22);

    // Randomised hold / stray start traffic with random idle gaps
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(0, 4)) tick();
      start_a(s0);
      wait_done_a(500, 1'b1, d);
    end
    repeat (4) tick();
    chk("a_queues_empty", qa.size() + wa.size(), 0);

    // Full LOGN=8, PE_LAT=5 transform
    ib.start = 1'b1;
    b_busy_cnt = 0;
    tick();
    ib.start = 1'b0;
    bd = -1;
    for (int i = 0; i < 2000; i++) begin
      if (ib.done) begin
        bd = cyc;
        break;
      end
      tick();
    end
    chk("b_done_seen", (bd >= 0), 1);
    chk("b_busy_cycles", b_busy_cnt, 1064);
    chk("b_done_after_last_wr", bd - b_last_wr, 1);
    chk("b_issue_count", b_idx, 1024);
    chk("b_write_count", b_wr_num, 1024);
    tick();
    chk("b_done_one_cycle", ib.done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
